breath_pwm_multi: RTL and testbench
===================================

# breath_pwm_multi

Multi-channel breathing-LED PWM generator: the parametrised successor to the single-channel breathing LED. It uses one shared PWM timebase and drives CHANNELS independent outputs. Each channel has a run-time mode (off / static duty / breathe / blink), a fixed phase offset so channels breathe staggered, and a glitch-free threshold update at PWM period boundaries. It sits between board-level control logic and the LED pins.

## Interface
- CHANNELS, 4: number of LED outputs (1..16)
- PWM_PERIOD, 10000: clk cycles per PWM period; the counter runs 0..PWM_PERIOD-1
- LEVEL_STEP, 1: level change per step tick
- STEP_PERIODS, 1: PWM periods per step tick (1..255)
- ACTIVE_LOW, 0: 1 = output pins inverted
- Derived: LVL_W = $clog2(PWM_PERIOD+1)+1
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  global enable
- mode  in  2*CHANNELS  per-channel mode, channel i at [2i+1:2i]: 0 OFF, 1 STATIC, 2 BREATH, 3 BLINK
- duty  in  CHANNELS*LVL_W  per-channel STATIC threshold, saturated to PWM_PERIOD
- led  out  CHANNELS  PWM outputs
- breath_wrap  out  CHANNELS  one-cycle pulse at the end of each channel's breath cycle

## Operation
- **Timebase.**
  - pwm_cnt counts 0..PWM_PERIOD-1 and wraps.
  - "boundary" = cycle with en=1 and pwm_cnt==PWM_PERIOD-1.
  - step_div counts boundaries 0..STEP_PERIODS-1.
  - "tick" = a boundary where step_div==STEP_PERIODS-1.
- **Level.** Per channel: level (LVL_W bits) and dir (1 = up). They update on tick in every mode.
  - Up: if level+LEVEL_STEP >= PWM_PERIOD, then level=PWM_PERIOD and dir=0; else level += LEVEL_STEP.
  - Down: if level <= LEVEL_STEP, then level=0, dir=1, and breath_wrap[i] pulses; else level -= LEVEL_STEP.
- **Phase init.** Let x = i*2*PWM_PERIOD/CHANNELS (integer).
  - x < PWM_PERIOD: level=x, dir=1.
  - Otherwise: level=2*PWM_PERIOD-x, dir=0.
- **Threshold.** thr[i] is loaded on every boundary from the current (pre-tick) level and mode:
  - OFF: 0
  - STATIC: min(duty_i, PWM_PERIOD)
  - BREATH: level
  - BLINK: dir ? PWM_PERIOD : 0
- Mode and duty are sampled only at boundaries. Changes mid-period never truncate a pulse.
- **Output.** led[i] <= (pwm_cnt < thr[i]) when en=1, else inactive. The value is XORed with ACTIVE_LOW.
  - thr = PWM_PERIOD gives a constant active output.
  - thr = 0 gives a constant inactive output.
- **Enable.** en=0 freezes pwm_cnt, step_div, level, dir and thr. led goes inactive on the next clock edge. Raising en resumes from the frozen state.

## Timing
- **Reset values (asynchronous):**
  - pwm_cnt=0, step_div=0, thr=0
  - level and dir = phase init
  - breath_wrap=0
  - led = inactive level (0 if ACTIVE_LOW=0, all ones if 1)
- **led latency:** 1 clk from pwm_cnt.
- **thr latency:** thr lags level by one PWM period.
  - The first period after reset always outputs inactive.
- **breath_wrap:** registered; asserted for exactly the cycle after the tick edge that hits 0.
- **Breath period:** 2*ceil(PWM_PERIOD/LEVEL_STEP)*STEP_PERIODS PWM periods.
- **Reset mid-operation:** everything returns to the reset values immediately; there is no partial pulse.

## Structure
- Package breath_pkg holds:
  - mode constants MODE_OFF, MODE_STATIC, MODE_BREATH, MODE_BLINK
  - the LVL_W calculation function
  - the phase-init function
- Sub-module breath_channel: one level/dir/thr/led slice per channel.
  - It is fed boundary, tick, pwm_cnt and en.
  - The top holds the shared timebase and a generate loop.

## Test plan
Unless noted, CHANNELS=4, PWM_PERIOD=8, LEVEL_STEP=2, STEP_PERIODS=1, ACTIVE_LOW=0.

- **Reset and phase init.**
  - Stimulus: hold rst_n low.
  - Response: led=0000 and breath_wrap=0000.
  - Internal (level, dir) = ch0 (0,up), ch1 (4,up), ch2 (8,down), ch3 (4,down).
- **ch0 BREATH.**
  - Stimulus: ch0 mode=2, en=1.
  - Response: high cycles per period are 0,0,2,4,6,8,6,4,2,0,2…
  - breath_wrap[0] pulses once every 64 clk; the first pulse follows the 8th tick.
- **STATIC saturation and boundary sampling.**
  - Stimulus: ch1 mode=1 with duty=3, then duty=20 written mid-period.
  - Response: 3 high cycles per period until the next boundary, then led constantly high.
- **BLINK.**
  - Stimulus: ch2 mode=3.
  - Response: led high for whole periods while dir=up and low while dir=down; each half lasts 4 periods.
- **Enable freeze.**
  - Stimulus: drop en mid-period for 5 clk.
  - Response: led=0000 from the next clk.
  - On re-enable, pwm_cnt and level continue from their frozen values.
  - No breath_wrap pulse occurs during the freeze.
- **Asynchronous reset mid-breath and ACTIVE_LOW.**
  - Stimulus: assert rst_n while ch0 level=6 (same bench); then rebuild with ACTIVE_LOW=1 and all modes OFF.
  - Response: level returns to 0 without waiting for a clock edge.
  - With ACTIVE_LOW=1 and all OFF, led=1111.

Source files
------------

// File: rtl/breath_pkg.sv
// Shared definitions for the multi-channel breathing PWM: channel modes,
// level-width sizing and the staggered start point of each channel.
package breath_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_BREATH = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  // One extra bit so level + step never wraps before the saturation compare.
  function automatic int lvl_w(input int period);
    return $clog2(period + 1) + 1;
  endfunction

  // Channels are spread evenly over one full up/down breath cycle.
  function automatic int phase_level(input int idx, input int channels, input int period);
    int x;
    x = idx * 2 * period / channels;
    return (x < period) ? x : 2 * period - x;
  endfunction

  function automatic logic phase_dir(input int idx, input int channels, input int period);
    int x;
    x = idx * 2 * period / channels;
    return (x < period);
  endfunction

endpackage

// File: rtl/breath_channel.sv
// One LED slice: triangle level generator, boundary-latched threshold and
// registered PWM compare against the shared counter.
module breath_channel
  import breath_pkg::*;
#(
  parameter int         PWM_PERIOD = 10000,
  parameter int         LEVEL_STEP = 1,
  parameter bit         ACTIVE_LOW = 1'b0,
  parameter int         LVL_W      = 15,
  parameter int         INIT_LEVEL = 0,
  parameter bit         INIT_DIR   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             boundary,
  input  logic             tick,
  input  logic [LVL_W-1:0] pwm_cnt,
  input  logic [1:0]       mode,
  input  logic [LVL_W-1:0] duty,
  output logic             led,
  output logic             breath_wrap
);

  localparam logic [LVL_W-1:0] PERIOD_L = LVL_W'(PWM_PERIOD);
  localparam logic [LVL_W-1:0] STEP_L   = LVL_W'(LEVEL_STEP);
  localparam logic [LVL_W-1:0] INIT_L   = LVL_W'(INIT_LEVEL);

  logic [LVL_W-1:0] level;
  logic             dir;
  logic [LVL_W-1:0] thr;
  logic [LVL_W-1:0] level_next;
  logic             dir_next;
  logic             wrap_next;
  logic [LVL_W-1:0] thr_next;

  always_comb begin
    level_next = level;
    dir_next   = dir;
    wrap_next  = 1'b0;
    if (dir) begin
      if (32'(level) + 32'(LEVEL_STEP) >= 32'(PWM_PERIOD)) begin
        level_next = PERIOD_L;
        dir_next   = 1'b0;
      end else begin
        level_next = level + STEP_L;
      end
    end else begin
      if (32'(level) <= 32'(LEVEL_STEP)) begin
        level_next = '0;
        dir_next   = 1'b1;
        wrap_next  = 1'b1;
      end else begin
        level_next = level - STEP_L;
      end
    end
  end

  // Threshold is built from the level as it stands before this boundary's tick.
  always_comb begin
    thr_next = '0;
    case (mode_e'(mode))
      MODE_OFF:    thr_next = '0;
      MODE_STATIC: thr_next = (32'(duty) > 32'(PWM_PERIOD)) ? PERIOD_L : duty;
      MODE_BREATH: thr_next = level;
      MODE_BLINK:  thr_next = dir ? PERIOD_L : '0;
      default:     thr_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level       <= INIT_L;
      dir         <= INIT_DIR;
      thr         <= '0;
      led         <= ACTIVE_LOW;
      breath_wrap <= 1'b0;
    end else begin
      breath_wrap <= 1'b0;
      if (boundary) thr <= thr_next;
      if (tick) begin
        level       <= level_next;
        dir         <= dir_next;
        breath_wrap <= wrap_next;
      end
      led <= ((pwm_cnt < thr) & en) ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/breath_pwm_multi.sv
// Multi-channel breathing LED PWM: shared period counter and step divider
// feeding one breath_channel slice per output.
module breath_pwm_multi
  import breath_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int PWM_PERIOD   = 10000,
  parameter int LEVEL_STEP   = 1,
  parameter int STEP_PERIODS = 1,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en,
  input  logic [2*CHANNELS-1:0]                  mode,
  input  logic [CHANNELS*lvl_w(PWM_PERIOD)-1:0]  duty,
  output logic [CHANNELS-1:0]                    led,
  output logic [CHANNELS-1:0]                    breath_wrap
);

  localparam int LVL_W = lvl_w(PWM_PERIOD);
  localparam int SD_W  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  localparam logic [LVL_W-1:0] CNT_LAST = LVL_W'(PWM_PERIOD - 1);
  localparam logic [SD_W-1:0]  SD_LAST  = SD_W'(STEP_PERIODS - 1);

  logic [LVL_W-1:0] pwm_cnt;
  logic [SD_W-1:0]  step_div;
  logic             boundary;
  logic             tick;

  assign boundary = en && (pwm_cnt == CNT_LAST);
  assign tick     = boundary && (step_div == SD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      step_div <= '0;
    end else begin
      if (boundary)  pwm_cnt <= '0;
      else if (en)   pwm_cnt <= pwm_cnt + 1'b1;
      if (tick)          step_div <= '0;
      else if (boundary) step_div <= step_div + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    breath_channel #(
      .PWM_PERIOD (PWM_PERIOD),
      .LEVEL_STEP (LEVEL_STEP),
      .ACTIVE_LOW (ACTIVE_LOW != 0),
      .LVL_W      (LVL_W),
      .INIT_LEVEL (phase_level(i, CHANNELS, PWM_PERIOD)),
      .INIT_DIR   (phase_dir(i, CHANNELS, PWM_PERIOD))
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .boundary    (boundary),
      .tick        (tick),
      .pwm_cnt     (pwm_cnt),
      .mode        (mode[2*i +: 2]),
      .duty        (duty[i*LVL_W +: LVL_W]),
      .led         (led[i]),
      .breath_wrap (breath_wrap[i])
    );
  end

endmodule

// File: tb/tb_breath_pwm_multi.sv
// Directed bench for breath_pwm_multi: PWM_PERIOD=8, LEVEL_STEP=2, four
// channels, plus an ACTIVE_LOW instance held in OFF.
module tb_breath_pwm_multi;

  localparam int P  = 8;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [7:0]    mode = '0;
  logic [4*LW-1:0] duty = '0;
  logic [3:0]    led;
  logic [3:0]    wrap;
  logic [7:0]    mode_al = '0;
  logic [4*LW-1:0] duty_al = '0;
  logic [3:0]    led_al;
  logic [3:0]    wrap_al;

  int n_assert = 0;
  int n_fail   = 0;
  int hi[4];
  logic [3:0] wrap_seen;

  always #5 clk = ~clk;

  breath_pwm_multi #(
    .CHANNELS(4), .PWM_PERIOD(P), .LEVEL_STEP(2), .STEP_PERIODS(1), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .duty(duty),
    .led(led), .breath_wrap(wrap)
  );

  breath_pwm_multi #(
    .CHANNELS(4), .PWM_PERIOD(P), .LEVEL_STEP(2), .STEP_PERIODS(1), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode_al), .duty(duty_al),
    .led(led_al), .breath_wrap(wrap_al)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_win();
    for (int c = 0; c < 4; c++) hi[c] = 0;
    wrap_seen = '0;
  endtask

  task automatic sample(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < 4; c++) hi[c] += (led[c] === 1'b1) ? 1 : 0;
      wrap_seen |= wrap;
    end
  endtask

  // Period p counts from 1 after reset release; thr of period p is the level after tick p-2.
  function automatic int ch0_hi(input int p);
    int k;
    if (p < 2) return 0;
    k = (p - 2) % 8;
    return (k <= 4) ? 2 * k : 2 * (8 - k);
  endfunction

  // Ticks on which each channel's level reaches 0 given the staggered start.
  function automatic logic [3:0] exp_wrap(input int p);
    int first[4];
    logic [3:0] r;
    first[0] = 8; first[1] = 6; first[2] = 4; first[3] = 2;
    r = '0;
    for (int c = 0; c < 4; c++)
      r[c] = (p >= first[c]) && (((p - first[c]) % 8) == 0);
    return r;
  endfunction

  task automatic period_check(input int p, input int e0, input int e1, input int e2, input int e3);
    string s;
    clear_win();
    sample(P);
    s = $sformatf("p%0d", p);
    check({s, "_hi0"}, 32'(hi[0]), 32'(e0));
    check({s, "_hi1"}, 32'(hi[1]), 32'(e1));
    check({s, "_hi2"}, 32'(hi[2]), 32'(e2));
    check({s, "_hi3"}, 32'(hi[3]), 32'(e3));
    check({s, "_wrap"}, 32'(wrap_seen), 32'(exp_wrap(p)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e2;
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_led_al", 32'(led_al), 32'hf);
    check("rst_lvl0", 32'(dut.g_ch[0].u_ch.level), 0);
    check("rst_dir0", 32'(dut.g_ch[0].u_ch.dir), 1);
    check("rst_lvl1", 32'(dut.g_ch[1].u_ch.level), 4);
    check("rst_dir1", 32'(dut.g_ch[1].u_ch.dir), 1);
    check("rst_lvl2", 32'(dut.g_ch[2].u_ch.level), 8);
    check("rst_dir2", 32'(dut.g_ch[2].u_ch.dir), 0);
    check("rst_lvl3", 32'(dut.g_ch[3].u_ch.level), 4);
    check("rst_dir3", 32'(dut.g_ch[3].u_ch.dir), 0);

    // ch0 breathes, everything else off
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = 8'b00_00_00_10;
    for (int p = 1; p <= 11; p++) period_check(p, ch0_hi(p), 0, 0, 0);

    // ch1 static duty 3; mode is only picked up at the end of period 12
    mode[3:2] = 2'd1;
    duty[2*LW-1:LW] = 5'd3;
    period_check(12, ch0_hi(12), 0, 0, 0);

    clear_win();
    sample(4);
    duty[2*LW-1:LW] = 5'd20;
    sample(4);
    check("p13_hi1_static3", 32'(hi[1]), 3);
    check("p13_hi0", 32'(hi[0]), 32'(ch0_hi(13)));
    check("p13_wrap", 32'(wrap_seen), 32'(exp_wrap(13)));
    period_check(14, ch0_hi(14), 8, 0, 0);

    // ch2 blink: follows dir, four periods per half
    mode[5:4] = 2'd3;
    for (int p = 15; p <= 27; p++) begin
      e2 = (p == 16 || p == 17 || (p >= 22 && p <= 25)) ? 8 : 0;
      period_check(p, ch0_hi(p), 8, e2, 0);
    end

    // freeze for 5 clk after two counts of period 28
    clear_win();
    sample(2);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("frz%0d_led", k), 32'(led), 32'h0);
      check($sformatf("frz%0d_wrap", k), 32'(wrap), 32'h0);
    end
    en = 1'b1;
    sample(6);
    check("p28_hi0_resume", 32'(hi[0]), 4);
    check("p28_hi1_resume", 32'(hi[1]), 8);
    check("p28_hi2_resume", 32'(hi[2]), 0);
    check("p28_wrap", 32'(wrap_seen), 32'(exp_wrap(28)));
    period_check(29, ch0_hi(29), 8, 0, 0);

    // asynchronous reset between clock edges while ch0 sits at level 6
    clear_win();
    sample(3);
    check("pre_rst_lvl0", 32'(dut.g_ch[0].u_ch.level), 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_lvl0", 32'(dut.g_ch[0].u_ch.level), 0);
    check("arst_dir0", 32'(dut.g_ch[0].u_ch.dir), 1);
    check("arst_lvl2", 32'(dut.g_ch[2].u_ch.level), 8);
    check("arst_led", 32'(led), 32'h0);
    check("arst_wrap", 32'(wrap), 32'h0);
    check("arst_led_al", 32'(led_al), 32'hf);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mode  = '0;
    for (int k = 0; k < P; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("off%0d_led_al", k), 32'(led_al), 32'hf);
      check($sformatf("off%0d_led", k), 32'(led), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
